// File: rtl/simon_serial_ctrl.sv
// simon_serial_ctrl
// Word-level front/back end for the bit-serial simon_core.
// A host hands over a parallel key and plaintext with a valid/ready handshake.
// The controller shifts the key and then the plaintext into the core one bit
// per clock, LSB first, with the matching data_rdy code. It then holds the core
// in run mode for RUN_CYCLES clocks. During the last BLOCK_W of those clocks it
// deserialises cipher_out into a parallel ciphertext word, which is offered
// back to the host through a second valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_in_valid   key/plaintext words valid
//   o_in_ready   controller can accept a new job (IDLE only)
//   i_key        encryption key, sampled on accept
//   i_pt         plaintext, sampled on accept
//   o_out_valid  o_ct holds a finished ciphertext
//   i_out_ready  consumer takes o_ct
//   o_ct         ciphertext word
//   o_busy       controller is not idle
//   o_data_in    serial bit to simon_core
//   o_data_rdy   core mode: 00 idle, 01 plaintext load, 10 key load, 11 run
//   i_cipher_out serial ciphertext bit from simon_core
module simon_serial_ctrl #(
    parameter int BLOCK_W    = 128,
    parameter int KEY_W      = 128,
    parameter int RUN_CYCLES = 8704
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [KEY_W-1:0]   i_key,
    input  logic [BLOCK_W-1:0] i_pt,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [BLOCK_W-1:0] o_ct,
    output logic               o_busy,
    output logic               o_data_in,
    output logic [1:0]         o_data_rdy,
    input  logic               i_cipher_out
);

    localparam int MAX_LOAD = (KEY_W > BLOCK_W) ? KEY_W : BLOCK_W;
    localparam int MAX_LEN  = (MAX_LOAD > RUN_CYCLES) ? MAX_LOAD : RUN_CYCLES;
    localparam int CNT_W    = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CT_FIRST = CNT_W'(RUN_CYCLES - BLOCK_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_PT,
        RUN,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CNT_W-1:0]   r_count;
    logic [KEY_W-1:0]   r_keyShift;
    logic [BLOCK_W-1:0] r_ptShift;
    logic [BLOCK_W-1:0] r_ct;
    logic               r_dataIn;
    logic [1:0]         r_dataRdy;
    logic               w_accept;
    logic               w_dataInNext;
    logic [1:0]         w_dataRdyNext;

    assign w_accept = i_in_valid && (r_state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: each phase ends when the shared counter hits its last index.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:     if (w_accept)              w_stateNext = LOAD_KEY;
            LOAD_KEY: if (r_count == KEY_LAST)   w_stateNext = LOAD_PT;
            LOAD_PT:  if (r_count == PT_LAST)    w_stateNext = RUN;
            RUN:      if (r_count == RUN_LAST)   w_stateNext = DONE;
            DONE:     if (i_out_ready)           w_stateNext = IDLE;
            default:                             w_stateNext = IDLE;
        endcase
    end

    // Output decode. The serial outputs are computed one clock ahead from the
    // next state so they can be registered and still line up with that state.
    // The shift registers keep the bit currently on the wire at index 0, so a
    // continuing load phase presents index 1 for the following clock.
    always_comb begin
        o_in_ready    = (r_state == IDLE);
        o_busy        = (r_state != IDLE);
        o_out_valid   = (r_state == DONE);
        w_dataRdyNext = 2'b00;
        w_dataInNext  = 1'b0;
        case (w_stateNext)
            LOAD_KEY: begin
                w_dataRdyNext = 2'b10;
                w_dataInNext  = (r_state == IDLE) ? i_key[0] : r_keyShift[1];
            end
            LOAD_PT: begin
                w_dataRdyNext = 2'b01;
                w_dataInNext  = (r_state == LOAD_KEY) ? r_ptShift[0] : r_ptShift[1];
            end
            RUN: begin
                w_dataRdyNext = 2'b11;
            end
            default: begin
                w_dataRdyNext = 2'b00;
                w_dataInNext  = 1'b0;
            end
        endcase
    end

    // Datapath: counter restarts on every state change, shift registers are
    // captured on accept and drained during their load phase, and ciphertext
    // bits enter at the MSB so the first captured bit ends up at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_keyShift <= '0;
            r_ptShift  <= '0;
            r_ct       <= '0;
            r_dataIn   <= 1'b0;
            r_dataRdy  <= 2'b00;
        end else begin
            r_dataIn  <= w_dataInNext;
            r_dataRdy <= w_dataRdyNext;

            if (w_stateNext != r_state) begin
                r_count <= '0;
            end else if (r_state == LOAD_KEY || r_state == LOAD_PT || r_state == RUN) begin
                r_count <= r_count + CNT_W'(1);
            end

            if (w_accept) begin
                r_keyShift <= i_key;
                r_ptShift  <= i_pt;
            end else begin
                if (r_state == LOAD_KEY) r_keyShift <= r_keyShift >> 1;
                if (r_state == LOAD_PT)  r_ptShift  <= r_ptShift >> 1;
            end

            if (r_state == RUN && r_count >= CT_FIRST) begin
                r_ct <= {i_cipher_out, r_ct[BLOCK_W-1:1]};
            end
        end
    end

    assign o_ct       = r_ct;
    assign o_data_in  = r_dataIn;
    assign o_data_rdy = r_dataRdy;

endmodule

// File: tb/tb_simon_serial_ctrl.sv
// tb_simon_serial_ctrl
// Directed, table-driven bench for simon_serial_ctrl with BLOCK_W=8, KEY_W=8,
// RUN_CYCLES=12. A small core stand-in plays back a chosen ciphertext on
// cipher_out during the last 8 run clocks, LSB first.
module tb_simon_serial_ctrl;

    localparam int BW = 8;
    localparam int KW = 8;
    localparam int RC = 12;
    localparam int LOAD_END = KW + BW;
    localparam int RUN_END  = KW + BW + RC;

    logic          clk;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic [KW-1:0] key;
    logic [BW-1:0] pt;
    logic          outValid;
    logic          outReady;
    logic [BW-1:0] ct;
    logic          busy;
    logic          dataIn;
    logic [1:0]    dataRdy;
    logic          cipherOut;

    logic [BW-1:0] coreCt;
    int            runIdx;
    int            checkCount;
    int            errorCount;

    typedef struct {
        logic [KW-1:0] key;
        logic [BW-1:0] pt;
        logic [BW-1:0] coreCt;
        logic [BW-1:0] expCt;
        bit            noise;
        int            holdCycles;
    } vec_t;

    vec_t vecs[3];

    simon_serial_ctrl #(
        .BLOCK_W    (BW),
        .KEY_W      (KW),
        .RUN_CYCLES (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_key        (key),
        .i_pt         (pt),
        .o_out_valid  (outValid),
        .i_out_ready  (outReady),
        .o_ct         (ct),
        .o_busy       (busy),
        .o_data_in    (dataIn),
        .o_data_rdy   (dataRdy),
        .i_cipher_out (cipherOut)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: counts run clocks and presents coreCt bits LSB first in
    // the final BW run clocks, changing on the falling edge.
    always @(negedge clk) begin
        if (dataRdy == 2'b11) begin
            if (runIdx >= RC - BW) cipherOut = coreCt[runIdx - (RC - BW)];
            else                   cipherOut = 1'b0;
            runIdx = runIdx + 1;
        end else begin
            runIdx    = 0;
            cipherOut = 1'b0;
        end
    end

    // Compare one observed value with its required value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Run one complete job: accept, check the serial stream clock by clock,
    // check the finished ciphertext, hold it for a while, then hand it off.
    task automatic applyStimulus(input vec_t v);
        logic [1:0] expRdy;
        logic       expDin;
        coreCt = v.coreCt;
        @(negedge clk);
        inValid = 1'b1;
        key     = v.key;
        pt      = v.pt;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        key     = ~v.key;
        pt      = ~v.pt;
        for (int k = 1; k <= RUN_END; k++) begin
            @(negedge clk);
            if (v.noise && k >= 10 && k <= 26) begin
                inValid = 1'b1;
                key     = KW'($urandom);
                pt      = BW'($urandom);
            end else begin
                inValid = 1'b0;
            end
            if (k <= KW) begin
                expRdy = 2'b10;
                expDin = v.key[k-1];
            end else if (k <= LOAD_END) begin
                expRdy = 2'b01;
                expDin = v.pt[k-1-KW];
            end else begin
                expRdy = 2'b11;
                expDin = 1'b0;
            end
            checkOutput($sformatf("data_rdy clk%0d", k), 32'(dataRdy), 32'(expRdy));
            checkOutput($sformatf("data_in clk%0d", k), 32'(dataIn), 32'(expDin));
            if (k == 20) begin
                checkOutput("busy mid-job", 32'(busy), 32'd1);
                checkOutput("in_ready mid-job", 32'(inReady), 32'd0);
                checkOutput("out_valid mid-job", 32'(outValid), 32'd0);
            end
        end
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("out_valid at done", 32'(outValid), 32'd1);
        checkOutput("ct at done", 32'(ct), 32'(v.expCt));
        checkOutput("data_rdy at done", 32'(dataRdy), 32'd0);
        for (int h = 0; h < v.holdCycles; h++) begin
            @(negedge clk);
            checkOutput("out_valid held", 32'(outValid), 32'd1);
            checkOutput("ct held", 32'(ct), 32'(v.expCt));
            checkOutput("data_rdy held", 32'(dataRdy), 32'd0);
            checkOutput("data_in held", 32'(dataIn), 32'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput("out_valid after handoff", 32'(outValid), 32'd0);
        checkOutput("in_ready after handoff", 32'(inReady), 32'd1);
        checkOutput("busy after handoff", 32'(busy), 32'd0);
        checkOutput("ct kept in idle", 32'(ct), 32'(v.expCt));
    endtask

    initial begin
        int firstStart;
        int secondStart;
        int validClocks;
        int doneSeen;
        logic [1:0] prevRdy;

        checkCount = 0;
        errorCount = 0;
        runIdx     = 0;
        cipherOut  = 1'b0;
        coreCt     = '0;
        rst        = 1'b1;
        inValid    = 1'b0;
        outReady   = 1'b0;
        key        = '0;
        pt         = '0;

        vecs[0] = '{key: 8'hA5, pt: 8'h3C, coreCt: 8'h96, expCt: 8'h96, noise: 1'b0, holdCycles: 10};
        vecs[1] = '{key: 8'h0F, pt: 8'hF0, coreCt: 8'h5A, expCt: 8'h5A, noise: 1'b1, holdCycles: 1};
        vecs[2] = '{key: 8'h81, pt: 8'h7E, coreCt: 8'hC3, expCt: 8'hC3, noise: 1'b0, holdCycles: 0};

        // Reset, then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset in_ready", 32'(inReady), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_valid", 32'(outValid), 32'd0);
        checkOutput("reset data_rdy", 32'(dataRdy), 32'd0);
        checkOutput("reset data_in", 32'(dataIn), 32'd0);
        checkOutput("reset ct", 32'(ct), 32'd0);

        // Table of jobs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the fifth run clock (clock 21 after accept).
        coreCt = 8'h96;
        @(negedge clk);
        inValid = 1'b1;
        key     = 8'hA5;
        pt      = 8'h3C;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (LOAD_END + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-run reset data_rdy", 32'(dataRdy), 32'd0);
        checkOutput("mid-run reset busy", 32'(busy), 32'd0);
        checkOutput("mid-run reset out_valid", 32'(outValid), 32'd0);
        checkOutput("mid-run reset in_ready", 32'(inReady), 32'd1);
        checkOutput("mid-run reset ct", 32'(ct), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0]);

        // Back-to-back jobs with in_valid and out_ready held high.
        coreCt      = 8'h96;
        firstStart  = -1;
        secondStart = -1;
        validClocks = 0;
        prevRdy     = 2'b00;
        @(negedge clk);
        key      = 8'hA5;
        pt       = 8'h3C;
        inValid  = 1'b1;
        outReady = 1'b1;
        for (int c = 0; c < 120 && secondStart < 0; c++) begin
            @(negedge clk);
            if (outValid && firstStart >= 0) validClocks = validClocks + 1;
            if (dataRdy == 2'b10 && prevRdy != 2'b10) begin
                if (firstStart < 0) firstStart = c;
                else                secondStart = c;
            end
            prevRdy = dataRdy;
        end
        inValid = 1'b0;
        checkOutput("first accept seen", 32'(firstStart >= 0), 32'd1);
        checkOutput("second accept seen", 32'(secondStart >= 0), 32'd1);
        checkOutput("clocks between accepts", 32'(secondStart - firstStart), 32'd30);
        checkOutput("out_valid clocks between accepts", 32'(validClocks), 32'd1);

        doneSeen = 0;
        for (int c = 0; c < 60 && doneSeen == 0; c++) begin
            @(negedge clk);
            if (outValid) doneSeen = 1;
        end
        checkOutput("second job done", 32'(doneSeen), 32'd1);
        checkOutput("second job ct", 32'(ct), 32'h96);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("second job consumed", 32'(outValid), 32'd0);
        checkOutput("idle after back-to-back", 32'(inReady), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
